control_unit_param: RTL and testbench
=====================================

// Module: control_unit_param
// PURPOSE
//   Parametrised successor of the CPU sequencing FSM for the ALU/RegFile datapath.
//   - Fetches IW-bit instructions from instruction memory with a valid handshake (wait states).
//   - Latches each instruction into an instruction register (IR) and decodes it into ALU opcode and RegFile addresses.
//   - Drives the RegFile write enable, supports HALT and branch-if-zero, and reports busy/done to the testbench/top.
// PARAMETERS
//   OPW      3           opcode width
//   RAW      2           register address width (2**RAW registers)
//   PCW      8           program counter width
//   HALT_OP  {OPW{1'b1}} opcode that terminates the program
//   BRZ_OP   {OPW{1'b1}}-1  opcode: branch if alu_zero; no RegFile write
//   IW       OPW+3*RAW   instruction width (derived; not to be overridden)
// PORTS
//   clk         in   1     clock, all state updates on rising edge
//   reset       in   1     synchronous, active-high reset
//   start       in   1     begin / restart program execution
//   instr       in   IW    instruction word {opcode, ra1, ra2, wa} at address pc
//   imem_valid  in   1     instr is valid for the current pc
//   alu_zero    in   1     ALU result == 0 for the current decoded operation
//   opcode      out  OPW   ALU operation
//   ra1         out  RAW   RegFile read address 1
//   ra2         out  RAW   RegFile read address 2
//   wa          out  RAW   RegFile write address
//   we          out  1     RegFile write enable
//   pc          out  PCW   program counter (instruction memory address)
//   busy        out  1     high in FETCH/EXECUTE/WRITEBACK/NEXT
//   done        out  1     high in DONE
// BEHAVIOUR
//   - Reset (sync): state=IDLE; pc=0; IR=0; br_take=0.
//     - All outputs are 0 from the first cycle after the reset edge.
//     - Reset overrides every other input, including mid-instruction; no write leaks after the edge.
//   - States: IDLE, FETCH, EXECUTE, WRITEBACK, NEXT, DONE. Outputs are combinational from state and IR.
//   - IDLE: all outputs 0; start=1 -> FETCH.
//   - FETCH: outputs 0.
//     - imem_valid=0 -> stay in FETCH (stall, pc held).
//     - imem_valid=1 -> IR<=instr; next state is DONE if instr[IW-1 -: OPW]==HALT_OP, otherwise EXECUTE.
//   - EXECUTE: {opcode,ra1,ra2,wa}=IR, we=0. br_take<=(IR.opcode==BRZ_OP)&alu_zero; -> WRITEBACK.
//   - WRITEBACK: decode from IR; we=1 unless IR.opcode==BRZ_OP; -> NEXT.
//   - NEXT: decode from IR, we=0.
//     - br_take=1: pc<={ra1,ra2,wa} of IR, zero-extended or truncated to PCW; -> FETCH.
//     - else if pc=={PCW{1'b1}} -> DONE; pc holds (no wrap).
//     - else pc<=pc+1 -> FETCH.
//     - br_take cleared in NEXT.
//   - DONE: done=1, we=0, pc held. start=1 -> pc<=0, IR<=0, -> FETCH. Otherwise stay in DONE.
//   - Unreachable state encodings -> IDLE.
//   - Latency: 4 cycles per non-HALT instruction with zero wait states.
//     - Each cycle instr is not valid in FETCH adds 1 cycle.
//   - we is high for exactly one cycle per non-branch instruction; never high in IDLE/FETCH/DONE.
//   - start is ignored in FETCH..NEXT.
//   - instr is ignored outside FETCH; a change of instr after the fetch does not alter the decode.
// TESTING
//   1. Reset, start, instr=9'b001_01_10_11 valid every FETCH
//      -> EXECUTE shows opcode=1, ra1=1, ra2=2, wa=3; we=1 only in WRITEBACK; pc 0->1 after 4 cycles.
//   2. imem_valid held low 3 cycles in FETCH -> FSM stalls; pc, we, and outputs stay 0; instruction completes in 7 cycles.
//   3. instr opcode=HALT at pc=2 -> DONE after FETCH, done=1, we never asserted, pc=2; start -> pc=0, FETCH.
//   4. BRZ with target 6'd5, alu_zero=1 -> we stays 0, pc=5 after NEXT.
//      Same instruction with alu_zero=0 -> pc+1.
//   5. pc preloaded to 255 by branch (PCW=8) -> after NEXT: done=1, pc stays 255, no wrap to 0.
//   6. reset asserted during WRITEBACK -> next cycle state IDLE, we=0, pc=0, done=0.
//      Re-run with OPW=4, RAW=3 (IW=13): scenario 1 decode correct.

Source files
------------

// File: rtl/control_unit_param.sv
// Parametrised CPU sequencing FSM: fetches instructions with a valid handshake,
// decodes them for the ALU/RegFile datapath and handles HALT and branch-if-zero.
module control_unit_param #(
  parameter int             OPW     = 3,
  parameter int             RAW     = 2,
  parameter int             PCW     = 8,
  parameter logic [OPW-1:0] HALT_OP = {OPW{1'b1}},
  parameter logic [OPW-1:0] BRZ_OP  = {{(OPW-1){1'b1}}, 1'b0}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [OPW+3*RAW-1:0]   instr,
  input  logic                   imem_valid,
  input  logic                   alu_zero,
  output logic [OPW-1:0]         opcode,
  output logic [RAW-1:0]         ra1,
  output logic [RAW-1:0]         ra2,
  output logic [RAW-1:0]         wa,
  output logic                   we,
  output logic [PCW-1:0]         pc,
  output logic                   busy,
  output logic                   done
);

  localparam int IW = OPW + 3*RAW;
  localparam int TW = 3*RAW;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    NEXT      = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t         state, state_next;
  logic [IW-1:0]  ir;
  logic           br_take;

  logic [OPW-1:0] ir_op;
  logic [TW-1:0]  ir_target;

  assign ir_op     = ir[IW-1 -: OPW];
  assign ir_target = ir[TW-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= '0;
      ir      <= '0;
      br_take <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        FETCH: begin
          if (imem_valid) ir <= instr;
        end
        EXECUTE: begin
          br_take <= (ir_op == BRZ_OP) && alu_zero;
        end
        NEXT: begin
          br_take <= 1'b0;
          // Branch target is the three register fields taken as one address.
          if (br_take)             pc <= PCW'(ir_target);
          else if (pc != {PCW{1'b1}}) pc <= pc + 1'b1;
        end
        DONE: begin
          if (start) begin
            pc <= '0;
            ir <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output and next-state signal gets a default before the case,
  // so no path through the block leaves a value unassigned (no latches).
  always_comb begin
    state_next = state;
    opcode     = '0;
    ra1        = '0;
    ra2        = '0;
    wa         = '0;
    we         = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        busy = 1'b1;
        if (imem_valid)
          state_next = (instr[IW-1 -: OPW] == HALT_OP) ? DONE : EXECUTE;
      end
      EXECUTE, WRITEBACK, NEXT: begin
        busy = 1'b1;
        {opcode, ra1, ra2, wa} = ir;
        if (state == EXECUTE) begin
          state_next = WRITEBACK;
        end else if (state == WRITEBACK) begin
          we         = (ir_op != BRZ_OP);
          state_next = NEXT;
        end else if (!br_take && pc == {PCW{1'b1}}) begin
          state_next = DONE;
        end else begin
          state_next = FETCH;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_unit_param.sv
// Self-checking bench for control_unit_param: default instance (OPW=3,RAW=2)
// and a wide instance (OPW=4,RAW=3), checked against a program-level model.
module tb_control_unit_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, imem_valid, alu_zero, use_b;
  logic [3:0] f_op;
  logic [2:0] f_r1, f_r2, f_w;

  logic [8:0]  instr_a;
  logic [12:0] instr_b;
  assign instr_a = {f_op[2:0], f_r1[1:0], f_r2[1:0], f_w[1:0]};
  assign instr_b = {f_op, f_r1, f_r2, f_w};

  logic [2:0] op_a;
  logic [1:0] r1_a, r2_a, wa_a;
  logic [3:0] op_b;
  logic [2:0] r1_b, r2_b, wa_b;
  logic       we_a, busy_a, done_a, we_b, busy_b, done_b;
  logic [7:0] pc_a, pc_b;
  logic       reset_a, reset_b;

  // The idle instance is held in reset so only the selected one runs.
  assign reset_a = reset | use_b;
  assign reset_b = reset | ~use_b;

  control_unit_param dut_a (
    .clk(clk), .reset(reset_a), .start(start), .instr(instr_a),
    .imem_valid(imem_valid), .alu_zero(alu_zero),
    .opcode(op_a), .ra1(r1_a), .ra2(r2_a), .wa(wa_a),
    .we(we_a), .pc(pc_a), .busy(busy_a), .done(done_a)
  );

  control_unit_param #(.OPW(4), .RAW(3), .PCW(8)) dut_b (
    .clk(clk), .reset(reset_b), .start(start), .instr(instr_b),
    .imem_valid(imem_valid), .alu_zero(alu_zero),
    .opcode(op_b), .ra1(r1_b), .ra2(r2_b), .wa(wa_b),
    .we(we_b), .pc(pc_b), .busy(busy_b), .done(done_b)
  );

  logic [23:0] obs;
  assign obs = use_b ? {op_b, r1_b, r2_b, wa_b, we_b, busy_b, done_b, pc_b}
                     : {1'b0, op_a, 1'b0, r1_a, 1'b0, r2_a, 1'b0, wa_a,
                        we_a, busy_a, done_a, pc_a};

  int passed = 0;
  int total  = 0;

  // Program-level model: current pc and whether the program has finished.
  int mpc;
  bit mdone;

  function automatic logic [23:0] snap(int op, int r1, int r2, int w,
                                       bit we, bit bsy, bit dn, int pcv);
    return {4'(op), 3'(r1), 3'(r2), 3'(w), we, bsy, dn, 8'(pcv)};
  endfunction

  function automatic int halt_op(); return use_b ? 15 : 7; endfunction
  function automatic int brz_op();  return use_b ? 14 : 6; endfunction
  function automatic int raw();     return use_b ? 3 : 2;  endfunction
  function automatic int rmax();    return use_b ? 7 : 3;  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input int op, input int r1, input int r2, input int w);
    f_op = 4'(op); f_r1 = 3'(r1); f_r2 = 3'(r2); f_w = 3'(w);
  endtask

  task automatic scramble_instr();
    set_instr($urandom_range(0, 15), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 7));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'($urandom);
    imem_valid = 1'($urandom);
    step();
    step();
    reset = 1'b0;
    start = 1'b0;
    mpc = 0;
    mdone = 0;
  endtask

  // Starts the program from IDLE or DONE; the machine must come up in FETCH at pc 0.
  task automatic restart(input string tag);
    start = 1'b1;
    imem_valid = 1'b0;
    step();
    start = 1'b0;
    mpc = 0;
    mdone = 0;
    total++;
    if (obs !== snap(0, 0, 0, 0, 0, 1, 0, 0))
      $display("FAIL %s restart: got %h expected %h", tag, obs, snap(0, 0, 0, 0, 0, 1, 0, 0));
    else passed++;
  endtask

  // Runs one instruction from FETCH, cycle by cycle, with 'waits' stall cycles.
  task automatic exec_instr(input int op, input int r1, input int r2, input int w,
                            input int waits, input bit az, input string tag);
    logic [23:0] e;
    for (int i = 0; i < waits; i++) begin
      imem_valid = 1'b0;
      scramble_instr();
      start = 1'($urandom);
      alu_zero = 1'($urandom);
      e = snap(0, 0, 0, 0, 0, 1, 0, mpc);
      total++;
      if (obs !== e) $display("FAIL %s stall%0d: got %h expected %h", tag, i, obs, e);
      else passed++;
      step();
    end
    imem_valid = 1'b1;
    set_instr(op, r1, r2, w);
    e = snap(0, 0, 0, 0, 0, 1, 0, mpc);
    total++;
    if (obs !== e) $display("FAIL %s fetch: got %h expected %h", tag, obs, e);
    else passed++;
    step();
    imem_valid = 1'($urandom);
    scramble_instr();
    if (op == halt_op()) begin
      start = 1'b0;
      mdone = 1;
      e = snap(0, 0, 0, 0, 0, 0, 1, mpc);
      total++;
      if (obs !== e) $display("FAIL %s halt: got %h expected %h", tag, obs, e);
      else passed++;
      return;
    end
    start = 1'($urandom);
    alu_zero = az;
    e = snap(op, r1, r2, w, 0, 1, 0, mpc);
    total++;
    if (obs !== e) $display("FAIL %s execute: got %h expected %h", tag, obs, e);
    else passed++;
    step();
    alu_zero = 1'($urandom);
    e = snap(op, r1, r2, w, op != brz_op(), 1, 0, mpc);
    total++;
    if (obs !== e) $display("FAIL %s writeback: got %h expected %h", tag, obs, e);
    else passed++;
    step();
    e = snap(op, r1, r2, w, 0, 1, 0, mpc);
    total++;
    if (obs !== e) $display("FAIL %s next: got %h expected %h", tag, obs, e);
    else passed++;
    if (op == brz_op() && az)
      mpc = ((r1 << (2*raw())) | (r2 << raw()) | w) % 256;
    else if (mpc == 255)
      mdone = 1;
    else
      mpc = mpc + 1;
    step();
    start = 1'b0;
    imem_valid = 1'b0;
    e = mdone ? snap(0, 0, 0, 0, 0, 0, 1, mpc) : snap(0, 0, 0, 0, 0, 1, 0, mpc);
    total++;
    if (obs !== e) $display("FAIL %s after: got %h expected %h", tag, obs, e);
    else passed++;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (obs !== snap(0, 0, 0, 0, 0, 0, 0, 0))
      $display("FAIL reset_state: got %h expected %h", obs, snap(0, 0, 0, 0, 0, 0, 0, 0));
    else passed++;
    imem_valid = 1'b1;
    set_instr(1, 1, 2, 3);
    step();
    total++;
    if (obs !== snap(0, 0, 0, 0, 0, 0, 0, 0))
      $display("FAIL idle_hold: got %h expected %h", obs, snap(0, 0, 0, 0, 0, 0, 0, 0));
    else passed++;
  endtask

  task automatic test_basic();
    restart("basic");
    exec_instr(1, 1, 2, 3, 0, 1'b0, "basic");
  endtask

  task automatic test_stall();
    do_reset();
    restart("stall");
    exec_instr(2, 3, 0, 1, 3, 1'b1, "stall");
  endtask

  task automatic test_halt();
    do_reset();
    restart("halt");
    exec_instr(3, 0, 1, 2, 0, 1'b0, "halt_i0");
    exec_instr(4, 2, 3, 1, 1, 1'b1, "halt_i1");
    exec_instr(halt_op(), 1, 1, 1, 0, 1'b0, "halt_i2");
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (obs !== snap(0, 0, 0, 0, 0, 0, 1, 2))
        $display("FAIL done_hold: got %h expected %h", obs, snap(0, 0, 0, 0, 0, 0, 1, 2));
      else passed++;
    end
    restart("after_halt");
  endtask

  task automatic test_branch();
    exec_instr(brz_op(), 0, 1, 1, 0, 1'b1, "brz_taken");
    exec_instr(brz_op(), 0, 1, 1, 0, 1'b0, "brz_not_taken");
  endtask

  task automatic test_random(input int n);
    int op;
    for (int k = 0; k < n; k++) begin
      if (mdone) restart("random");
      op = $urandom_range(0, halt_op());
      if (op == halt_op() && $urandom_range(0, 3) != 0) op = 0;
      exec_instr(op, $urandom_range(0, rmax()), $urandom_range(0, rmax()),
                 $urandom_range(0, rmax()), $urandom_range(0, 2), 1'($urandom), "random");
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    restart("reset_mid");
    imem_valid = 1'b1;
    set_instr(5, 1, 2, 3);
    step();
    imem_valid = 1'b0;
    step();
    total++;
    if (obs !== snap(5, 1, 2, 3, 1, 1, 0, 0))
      $display("FAIL mid_writeback: got %h expected %h", obs, snap(5, 1, 2, 3, 1, 1, 0, 0));
    else passed++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if (obs !== snap(0, 0, 0, 0, 0, 0, 0, 0))
      $display("FAIL mid_reset: got %h expected %h", obs, snap(0, 0, 0, 0, 0, 0, 0, 0));
    else passed++;
    mpc = 0;
    mdone = 0;
  endtask

  task automatic test_wide();
    use_b = 1'b1;
    do_reset();
    total++;
    if (obs !== snap(0, 0, 0, 0, 0, 0, 0, 0))
      $display("FAIL wide_reset: got %h expected %h", obs, snap(0, 0, 0, 0, 0, 0, 0, 0));
    else passed++;
    restart("wide");
    exec_instr(1, 1, 2, 3, 0, 1'b0, "wide_decode");
    exec_instr(9, 7, 5, 6, 1, 1'b1, "wide_decode2");
    // Target 9'h1FF truncates to pc 255.
    exec_instr(brz_op(), 7, 7, 7, 0, 1'b1, "wide_brz255");
    exec_instr(2, 4, 5, 6, 0, 1'b0, "wide_last");
    total++;
    if (obs !== snap(0, 0, 0, 0, 0, 0, 1, 255))
      $display("FAIL no_wrap: got %h expected %h", obs, snap(0, 0, 0, 0, 0, 0, 1, 255));
    else passed++;
    restart("wide_restart");
    test_random(25);
  endtask

  initial begin
    use_b = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    imem_valid = 1'b0;
    alu_zero = 1'b0;
    set_instr(0, 0, 0, 0);
    mpc = 0;
    mdone = 0;
    test_reset();
    test_basic();
    test_stall();
    test_halt();
    test_branch();
    test_random(40);
    test_reset_mid();
    test_wide();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
